// File: rtl/me_sprite_fetch.sv
// Player sprite ROM read engine: raster-to-ROM addressing, ROM latency realignment,
// chroma-key transparency and frame-tick animation sequencing. Optional ME_MIRROR_EN.
module me_sprite_fetch #(
    parameter int          SPR_W     = 100,
    parameter int          SPR_H     = 100,
    parameter int          ATK_W     = 120,
    parameter int          WALK_DIV  = 8,
    parameter int          ATK_HOLD  = 4,
    parameter int          HURT_HOLD = 16,
    parameter logic [23:0] KEY_RGB0  = 24'ha664ff,
    parameter logic [23:0] KEY_RGB1  = 24'h9140ff
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  SprX,
    input  logic [9:0]  SprY,
    input  logic        walk,
    input  logic        attack_req,
    input  logic        hit,
    input  logic        facing_left,
    input  logic [23:0] rom_rgb,
    output logic [7:0]  state,
    output logic [15:0] relative_address,
    output logic        pixel_on,
    output logic [23:0] pixel_rgb,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_WALK, S_ATK0, S_ATK1, S_ATK2, S_ATK3, S_HURT
    } fsm_t;

    fsm_t        cur, nxt;
    logic [7:0]  cnt, cnt_n;
    logic        phase, phase_n;
    logic [2:0]  fs;
    logic        tick;
    logic        atk;
    logic [1:0]  vld_pipe;

    // fs[1:0] synchronise frame_clk, fs[2] holds the previous synchronised level
    assign tick = fs[1] & ~fs[2];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fs    <= '0;
            cur   <= S_IDLE;
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            fs    <= {fs[1:0], frame_clk};
            cur   <= nxt;
            cnt   <= cnt_n;
            phase <= phase_n;
        end
    end

    always_comb begin
        nxt     = cur;
        cnt_n   = cnt;
        phase_n = phase;
        if (tick) begin
            case (cur)
                S_IDLE: begin
                    cnt_n   = '0;
                    phase_n = 1'b0;
                    if (hit)             nxt = S_HURT;
                    else if (attack_req) nxt = S_ATK0;
                    else if (walk)       nxt = S_WALK;
                end
                S_WALK: begin
                    if (hit) begin
                        nxt   = S_HURT;
                        cnt_n = '0;
                    end else if (attack_req) begin
                        nxt   = S_ATK0;
                        cnt_n = '0;
                    end else if (!walk) begin
                        nxt   = S_IDLE;
                        cnt_n = '0;
                    end else if (cnt == 8'(WALK_DIV - 1)) begin
                        phase_n = ~phase;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                S_ATK0, S_ATK1, S_ATK2, S_ATK3: begin
                    if (hit) begin
                        nxt   = S_HURT;
                        cnt_n = '0;
                    end else if (cnt == 8'(ATK_HOLD - 1)) begin
                        cnt_n = '0;
                        case (cur)
                            S_ATK0:  nxt = S_ATK1;
                            S_ATK1:  nxt = S_ATK2;
                            S_ATK2:  nxt = S_ATK3;
                            default: nxt = S_IDLE;
                        endcase
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                S_HURT: begin
                    // a fresh hit restarts the hold
                    if (hit) begin
                        cnt_n = '0;
                    end else if (cnt == 8'(HURT_HOLD - 1)) begin
                        nxt   = S_IDLE;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                default: begin
                    nxt   = S_IDLE;
                    cnt_n = '0;
                end
            endcase
        end

        state = 8'h01;
        busy  = 1'b0;
        atk   = 1'b0;
        case (cur)
            S_WALK: state = phase ? 8'h02 : 8'h01;
            S_ATK0: begin state = 8'h06; busy = 1'b1; atk = 1'b1; end
            S_ATK1: begin state = 8'h07; busy = 1'b1; atk = 1'b1; end
            S_ATK2: begin state = 8'h09; busy = 1'b1; atk = 1'b1; end
            S_ATK3: begin state = 8'h08; busy = 1'b1; atk = 1'b1; end
            S_HURT: begin state = 8'h05; busy = 1'b1; end
            default: state = 8'h01;
        endcase
    end

    // Address generation; bit 10 of the 11-bit differences is the sign
    logic [10:0] dx, dy;
    logic [15:0] dx16, dy16, w16, xs, addr_n;
    logic        inbox;

    assign dx   = {1'b0, DrawX} - {1'b0, SprX};
    assign dy   = {1'b0, DrawY} - {1'b0, SprY};
    assign dx16 = {6'd0, dx[9:0]};
    assign dy16 = {6'd0, dy[9:0]};
    assign w16  = atk ? 16'(ATK_W) : 16'(SPR_W);

`ifdef ME_MIRROR_EN
    logic face;

    always_ff @(posedge Clk) begin
        if (Reset)     face <= 1'b0;
        else if (tick) face <= facing_left;
    end

    assign xs = face ? (w16 - 16'd1 - dx16) : dx16;
`else
    logic unused_facing;
    assign unused_facing = facing_left;
    assign xs = dx16;
`endif

    assign inbox  = !dx[10] && !dy[10] && (dx16 < w16) && (dy16 < 16'(SPR_H));
    assign addr_n = inbox ? (dy16 * w16 + xs) : 16'd0;

    // vld_pipe[0] travels with the address, vld_pipe[1] lines up with rom_rgb
    logic opaque;
    assign opaque = vld_pipe[1] && (rom_rgb != KEY_RGB0) && (rom_rgb != KEY_RGB1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            relative_address <= '0;
            vld_pipe         <= '0;
            pixel_on         <= 1'b0;
            pixel_rgb        <= '0;
        end else begin
            relative_address <= addr_n;
            vld_pipe         <= {vld_pipe[0], inbox};
            pixel_on         <= opaque;
            pixel_rgb        <= opaque ? rom_rgb : 24'd0;
        end
    end

endmodule

// File: tb/tb_me_sprite_fetch.sv
// Scoreboard bench for me_sprite_fetch: address/pixel pipeline and animation sequencing.
module tb_me_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  DrawX, DrawY, SprX, SprY;
    logic        walk, attack_req, hit, facing_left;
    logic [23:0] rom_rgb;
    logic [7:0]  state;
    logic [15:0] relative_address;
    logic        pixel_on;
    logic [23:0] pixel_rgb;
    logic        busy;

    me_sprite_fetch dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .DrawX(DrawX), .DrawY(DrawY), .SprX(SprX), .SprY(SprY),
        .walk(walk), .attack_req(attack_req), .hit(hit), .facing_left(facing_left),
        .rom_rgb(rom_rgb), .state(state), .relative_address(relative_address),
        .pixel_on(pixel_on), .pixel_rgb(pixel_rgb), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [9:0]  x, y, sx, sy;
        logic [23:0] rgb;
    } pix_t;

    pix_t        tab[$];
    logic [15:0] addr_q[$];
    logic [24:0] pix_q[$];
    logic [8:0]  st_q[$];

    function automatic logic [16:0] model(input pix_t p, input int w, input bit face);
        int dx, dy, xa;
        logic in_b;
        dx   = int'(p.x) - int'(p.sx);
        dy   = int'(p.y) - int'(p.sy);
        in_b = (dx >= 0) && (dx < w) && (dy >= 0) && (dy < 100);
        xa   = face ? (w - 1 - dx) : dx;
        return {in_b, in_b ? 16'(dy * w + xa) : 16'd0};
    endfunction

    function automatic bit is_key(input logic [23:0] c);
        return (c == 24'ha664ff) || (c == 24'h9140ff);
    endfunction

    // Drives tab[] one entry per cycle; ROM data for entry n is presented two cycles later
    task automatic run(input int w, input bit face);
        logic [16:0] m;
        logic [15:0] a;
        logic [24:0] e;
        bit          op;
        for (int n = 0; n < tab.size() + 3; n++) begin
            @(negedge Clk);
            if (addr_q.size() > 0) begin
                a = addr_q.pop_front();
                chk("addr", 32'(relative_address), 32'(a));
            end
            if (pix_q.size() > 0) begin
                e = pix_q.pop_front();
                chk("pix_on", 32'(pixel_on), 32'(e[24]));
                chk("pix_rgb", 32'(pixel_rgb), 32'(e[23:0]));
            end
            if (n < tab.size()) begin
                DrawX = tab[n].x; DrawY = tab[n].y; SprX = tab[n].sx; SprY = tab[n].sy;
                m = model(tab[n], w, face);
                addr_q.push_back(m[15:0]);
            end else begin
                DrawX = 10'd1023; DrawY = 10'd1023; SprX = 10'd0; SprY = 10'd0;
            end
            if (n >= 2 && n - 2 < tab.size()) begin
                rom_rgb = tab[n-2].rgb;
                m  = model(tab[n-2], w, face);
                op = m[16] && !is_key(tab[n-2].rgb);
                pix_q.push_back({op, op ? tab[n-2].rgb : 24'd0});
            end else begin
                rom_rgb = 24'd0;
            end
        end
        tab.delete();
    endtask

    task automatic tick_chk(input logic [7:0] st, input logic b);
        logic [8:0] e;
        st_q.push_back({b, st});
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        e = st_q.pop_front();
        chk("state", 32'(state), 32'(e[7:0]));
        chk("busy", 32'(busy), 32'(e[8]));
    endtask

    initial begin
        logic [7:0] atk_seq [4];
        atk_seq[0] = 8'h06; atk_seq[1] = 8'h07; atk_seq[2] = 8'h09; atk_seq[3] = 8'h08;
        SprX = 10'd100; SprY = 10'd100; DrawX = 10'd0; DrawY = 10'd0;
        walk = 0; attack_req = 0; hit = 0; facing_left = 0; rom_rgb = 24'd0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_state", 32'(state), 32'h01);
        chk("rst_addr", 32'(relative_address), 32'd0);
        chk("rst_pix_on", 32'(pixel_on), 32'd0);
        chk("rst_pix_rgb", 32'(pixel_rgb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Idle-width addressing, keying and box edges
        tab.push_back({10'd110, 10'd53, 10'd100, 10'd50, 24'hffffff});
        tab.push_back({10'd110, 10'd53, 10'd100, 10'd50, 24'ha664ff});
        tab.push_back({10'd110, 10'd53, 10'd100, 10'd50, 24'h9140ff});
        tab.push_back({10'd99,  10'd53, 10'd100, 10'd50, 24'h123456});
        tab.push_back({10'd199, 10'd149, 10'd100, 10'd50, 24'habcdef});
        tab.push_back({10'd200, 10'd53, 10'd100, 10'd50, 24'h00ff00});
        tab.push_back({10'd100, 10'd150, 10'd100, 10'd50, 24'h00ff00});
        tab.push_back({10'd639, 10'd479, 10'd600, 10'd400, 24'h0000aa});
        tab.push_back({10'd5,   10'd10, 10'd0,   10'd50, 24'h111111});
        run(100, 1'b0);
        chk("addr_310", 32'(model({10'd110, 10'd53, 10'd100, 10'd50, 24'd0}, 100, 1'b0)), 32'h10136);

        // Walk: 8 ticks of 01, 8 of 02, then back to 01
        walk = 1;
        for (int k = 1; k <= 17; k++) tick_chk((k <= 8 || k == 17) ? 8'h01 : 8'h02, 1'b0);
        walk = 0;
        tick_chk(8'h01, 1'b0);

        // Attack sequence with the wider frame and an ignored re-trigger
        attack_req = 1;
        tick_chk(8'h06, 1'b1);
        attack_req = 0;
        tab.push_back({10'd119, 10'd0,  10'd0, 10'd0, 24'h00ff00});
        tab.push_back({10'd120, 10'd0,  10'd0, 10'd0, 24'h00ff00});
        tab.push_back({10'd119, 10'd99, 10'd0, 10'd0, 24'h336699});
        run(120, 1'b0);
        for (int k = 2; k <= 16; k++) begin
            attack_req = (k == 6);
            tick_chk(atk_seq[(k-1)/4], 1'b1);
        end
        attack_req = 0;
        tick_chk(8'h01, 1'b0);

        // Hit preempts ATK1; a second hit restarts the hurt hold
        attack_req = 1;
        tick_chk(8'h06, 1'b1);
        attack_req = 0;
        for (int k = 2; k <= 5; k++) tick_chk(k <= 4 ? 8'h06 : 8'h07, 1'b1);
        hit = 1;
        tick_chk(8'h05, 1'b1);
        hit = 0;
        for (int k = 0; k < 4; k++) tick_chk(8'h05, 1'b1);
        hit = 1; attack_req = 1;
        tick_chk(8'h05, 1'b1);
        hit = 0; attack_req = 0;
        for (int k = 0; k < 15; k++) tick_chk(8'h05, 1'b1);
        tick_chk(8'h01, 1'b0);

        // Reset in the middle of an attack
        attack_req = 1;
        tick_chk(8'h06, 1'b1);
        attack_req = 0;
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_state", 32'(state), 32'h01);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pix_on", 32'(pixel_on), 32'd0);
        Reset = 1'b0;

`ifdef ME_MIRROR_EN
        facing_left = 1;
        tick_chk(8'h01, 1'b0);
        tab.push_back({10'd100, 10'd50, 10'd100, 10'd50, 24'h111111});
        tab.push_back({10'd150, 10'd60, 10'd100, 10'd50, 24'h222222});
        run(100, 1'b1);
        facing_left = 0;
        tick_chk(8'h01, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
